// File: rtl/spawn_generator.sv
// spawn_generator: paced, handshaked spawn descriptors for the falling-object core.
// A Galois LFSR sample is reduced modulo POS_RANGE bit-serially, then offered on valid/ready.
module spawn_generator #(
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(16'hACE1),
  parameter int unsigned       POS_RANGE  = 640,
  parameter int unsigned       POS_W      = 10,
  parameter int unsigned       SPEED_W    = 4,
  parameter int unsigned       DATA_W     = 24,
  parameter int unsigned       INTERVAL_W = 16,
  parameter int unsigned       COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic                  spawn_ready,
  output logic                  spawn_valid,
  output logic [DATA_W-1:0]     spawn_data,
  output logic [COUNT_W-1:0]    spawn_count
);

  // Feedback mask for x^16+x^14+x^13+x^11+1 in right-shift Galois form.
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(32'h0000_B400);
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [LFSR_W-1:0] SEED_EFF =
    (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam int unsigned BW = $clog2(LFSR_W + 1);
  localparam logic [POS_W:0] RANGE = (POS_W+1)'(POS_RANGE);
  localparam logic [BW-1:0]  LAST = BW'(LFSR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REDUCE,
    S_OFFER
  } state_e;

  state_e                  state_q;
  logic [LFSR_W-1:0]       lfsr_q;
  logic [LFSR_W-1:0]       lfsr_d;
  logic [INTERVAL_W-1:0]   cnt_q;
  logic [LFSR_W-1:0]       sample_q;
  logic [POS_W-1:0]        rem_q;
  logic [POS_W-1:0]        rem_d;
  logic [POS_W:0]          trial;
  logic [BW-1:0]           bit_q;
  logic [SPEED_W-1:0]      speed_d;
  logic [DATA_W-1:0]       desc_d;
  logic                    valid_q;
  logic [DATA_W-1:0]       data_q;
  logic [COUNT_W-1:0]      count_q;

  // Next LFSR value: shift right, fold in taps when a one drops out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ TAPS;
    end
  end

  // LFSR free-runs in every state so spawn timing does not bias it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // One restoring-division step: bring in the next sample bit, subtract if it fits.
  always_comb begin
    trial = {rem_q, sample_q[LFSR_W-1]};
    rem_d = trial[POS_W-1:0];
    if (trial >= RANGE) begin
      rem_d = POS_W'(trial - RANGE);
    end
  end

  // Descriptor built from the final remainder and a never-zero speed.
  always_comb begin
    speed_d = lfsr_q[SPEED_W-1:0];
    if (speed_d == '0) begin
      speed_d = SPEED_W'(1);
    end
    desc_d                      = '0;
    desc_d[DATA_W-1]            = 1'b1;
    desc_d[DATA_W-2 -: SPEED_W] = speed_d;
    desc_d[POS_W-1:0]           = rem_d;
  end

  // Spawn FSM: pace, reduce, then hold the offer until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sample_q <= '0;
      rem_q    <= '0;
      bit_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_WAIT;
            cnt_q   <= interval;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            sample_q <= lfsr_q;
            rem_q    <= '0;
            bit_q    <= '0;
            state_q  <= S_REDUCE;
          end else begin
            cnt_q <= cnt_q - INTERVAL_W'(1);
          end
        end
        S_REDUCE: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else begin
            sample_q <= sample_q << 1;
            rem_q    <= rem_d;
            bit_q    <= bit_q + BW'(1);
            if (bit_q == LAST) begin
              data_q  <= desc_d;
              valid_q <= 1'b1;
              state_q <= S_OFFER;
            end
          end
        end
        S_OFFER: begin
          // The offer is never withdrawn; enable only decides where to go next.
          if (spawn_ready) begin
            valid_q <= 1'b0;
            count_q <= count_q + COUNT_W'(1);
            if (enable) begin
              state_q <= S_WAIT;
              cnt_q   <= interval;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_data  = data_q;
  assign spawn_count = count_q;

endmodule

// File: tb/tb_spawn_generator.sv
// tb_spawn_generator: scoreboard of predicted descriptors plus timing tables
// and hand-written reset, backpressure, enable and wrap sequences.
module tb_spawn_generator;

  localparam int RANGE = 640;
  localparam int LFN   = 80000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] interval;
  logic        spawn_ready;
  logic        spawn_valid;
  logic [23:0] spawn_data;
  logic [15:0] spawn_count;

  logic        en1;
  logic        rdy1;
  logic [15:0] iv1 = 16'd0;
  logic        v1;
  logic [23:0] d1;
  logic [3:0]  c1;

  always #5 clk = ~clk;

  spawn_generator u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .interval    (interval),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_data  (spawn_data),
    .spawn_count (spawn_count)
  );

  spawn_generator #(
    .POS_RANGE (1),
    .COUNT_W   (4)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (en1),
    .interval    (iv1),
    .spawn_ready (rdy1),
    .spawn_valid (v1),
    .spawn_data  (d1),
    .spawn_count (c1)
  );

  int errors = 0;
  int checks = 0;
  int edge_no = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at edge %0d",
               name, act, exp, edge_no);
    end
  endtask

  // LFSR reference: values after k edges since reset release.
  logic [15:0] lf [LFN];

  // Scoreboard model.
  typedef enum {M_IDLE, M_BUSY, M_OFFER} mst_e;
  mst_e        m_st;
  int          m_k;
  logic        m_valid;
  logic [23:0] m_data;
  logic [15:0] m_count;
  logic [23:0] sbq[$];
  int          dueq[$];

  function automatic logic [23:0] predict(int k, int iv);
    logic [15:0] s;
    logic [3:0]  sp;
    s  = lf[k + iv];
    sp = lf[k + iv + 16][3:0];
    if (sp == 4'd0) sp = 4'd1;
    return {1'b1, sp, 9'd0, 10'(s % RANGE)};
  endfunction

  task automatic sb_push();
    sbq.push_back(predict(m_k, int'(interval)));
    dueq.push_back(m_k + int'(interval) + 17);
  endtask

  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) begin
      m_st    = M_IDLE;
      m_k     = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_count = '0;
      sbq.delete();
      dueq.delete();
    end else begin
      m_k++;
      case (m_st)
        M_IDLE: if (enable) begin
          sb_push();
          m_st = M_BUSY;
        end
        M_BUSY: if (!enable) begin
          sbq.delete();
          dueq.delete();
          m_st = M_IDLE;
        end else if (dueq.size() > 0 && m_k == dueq[0]) begin
          m_data = sbq.pop_front();
          void'(dueq.pop_front());
          m_valid = 1'b1;
          m_st = M_OFFER;
        end
        M_OFFER: if (spawn_ready) begin
          m_valid = 1'b0;
          m_count++;
          if (enable) begin
            sb_push();
            m_st = M_BUSY;
          end else begin
            m_st = M_IDLE;
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  logic prev_v = 1'b0;

  always @(posedge clk) begin
    #1;
    chk("valid", 32'(spawn_valid), 32'(m_valid));
    chk("data", 32'(spawn_data), 32'(m_data));
    chk("count", 32'(spawn_count), 32'(m_count));
    if (spawn_valid && !prev_v) begin
      chk("pos_lt_range", 32'(spawn_data[9:0] < 10'd640), 32'd1);
      chk("top_bit", 32'(spawn_data[23]), 32'd1);
    end
    prev_v = spawn_valid;
  end

  task automatic wait_valid(input logic lvl, input int lim, output int e);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (spawn_valid !== lvl && n < lim);
    if (spawn_valid !== lvl) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: valid=%0b, required %0b within %0d cycles",
               spawn_valid, lvl, lim);
    end
    e = edge_no;
  endtask

  task automatic handshake(input int stall, output int h);
    int n = 0;
    @(negedge clk);
    spawn_ready = 1'b0;
    while (spawn_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (spawn_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: valid=%0b, required 1", spawn_valid);
    end
    repeat (stall) @(negedge clk);
    spawn_ready = 1'b1;
    @(posedge clk);
    #1;
    h = edge_no;
    @(negedge clk);
    spawn_ready = 1'b0;
  endtask

  task automatic do_release(input logic [15:0] iv);
    @(negedge clk);
    rst_n       = 1'b1;
    enable      = 1'b1;
    interval    = iv;
    spawn_ready = 1'b1;
  endtask

  typedef struct {
    int intv;
    int stall;
    int period;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int e;
    int e0;
    int e2;
    int h1;
    int h2;
    int n;
    logic [15:0] mask;
    logic [23:0] pw_desc;

    tbl[0] = '{intv: 0,  stall: 0,  period: 18};
    tbl[1] = '{intv: 5,  stall: 0,  period: 23};
    tbl[2] = '{intv: 3,  stall: 4,  period: 25};
    tbl[3] = '{intv: 12, stall: 1,  period: 31};
    tbl[4] = '{intv: 1,  stall: 10, period: 29};

    // Galois mask from exponents 16,14,13,11 of the polynomial.
    mask = (16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10);
    lf[0] = 16'hACE1;
    for (int i = 1; i < LFN; i++) begin
      lf[i] = lf[i-1] >> 1;
      if (lf[i-1][0]) lf[i] = lf[i] ^ mask;
    end

    rst_n       = 1'b0;
    enable      = 1'b0;
    interval    = 16'd0;
    spawn_ready = 1'b0;
    en1         = 1'b0;
    rdy1        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(spawn_valid), 32'd0);
    chk("rst_data", 32'(spawn_data), 32'd0);
    chk("rst_count", 32'(spawn_count), 32'd0);

    // Pacing: first offer 1+6+16 edges after enable, then 23 apart.
    do_release(16'd5);
    e0 = edge_no;
    wait_valid(1'b1, 100, e);
    chk("t2_first_latency", 32'(e - e0), 32'd23);
    pw_desc = m_data;
    for (int i = 0; i < 3; i++) begin
      wait_valid(1'b0, 5, e2);
      wait_valid(1'b1, 100, e2);
      chk("t2_period", 32'(e2 - e), 32'd23);
      e = e2;
    end

    // Reset in mid-REDUCE clears outputs at once.
    wait_valid(1'b0, 5, e2);
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 32'(spawn_valid), 32'd0);
    chk("t1_data", 32'(spawn_data), 32'd0);
    chk("t1_count", 32'(spawn_count), 32'd0);
    repeat (2) @(negedge clk);
    do_release(16'd5);
    e0 = edge_no;
    wait_valid(1'b1, 100, e);
    chk("t1_latency", 32'(e - e0), 32'd23);
    chk("t1_same_desc", 32'(spawn_data), 32'(pw_desc));

    // Backpressure: offer held, count frozen.
    @(negedge clk);
    spawn_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      chk("t4_valid_held", 32'(spawn_valid), 32'd1);
      chk("t4_data_held", 32'(spawn_data), 32'(pw_desc));
      chk("t4_count_held", 32'(spawn_count), 32'd0);
    end
    @(negedge clk);
    spawn_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_count_inc", 32'(spawn_count), 32'd1);
    chk("t4_valid_drop", 32'(spawn_valid), 32'd0);

    // Enable dropped during REDUCE aborts without an offer.
    @(negedge clk);
    spawn_ready = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    interval = 16'd2;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      chk("t5_abort_no_valid", 32'(spawn_valid), 32'd0);
    end
    chk("t5_abort_count", 32'(spawn_count), 32'd1);

    // Enable dropped in OFFER: offer kept, accepted, then idle.
    @(negedge clk);
    enable = 1'b1;
    wait_valid(1'b1, 100, e);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t5_offer_held", 32'(spawn_valid), 32'd1);
    end
    @(negedge clk);
    spawn_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_count_inc", 32'(spawn_count), 32'd2);
    chk("t5_valid_drop", 32'(spawn_valid), 32'd0);
    @(negedge clk);
    spawn_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("t5_idle", 32'(spawn_valid), 32'd0);
    end

    // Handshake spacing table: interval + 18 + stall.
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      interval = 16'(tbl[i].intv);
      handshake(tbl[i].stall, h1);
      handshake(tbl[i].stall, h2);
      chk($sformatf("tbl_period_%0d", i), 32'(h2 - h1),
          32'(tbl[i].period));
    end

    // Long run against the LFSR/modulo model.
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    do_release(16'd0);
    n = 0;
    while (m_count < 16'd2000 && n < 2000 * 19 + 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t3_count", 32'(spawn_count), 32'd2000);
    @(negedge clk);
    enable = 1'b0;
    spawn_ready = 1'b0;

    // POS_RANGE=1, COUNT_W=4 instance: pos 0, speed nonzero, count wraps.
    en1 = 1'b1;
    rdy1 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (v1 !== 1'b1 && n < 40);
      chk("t6_valid", 32'(v1), 32'd1);
      chk("t6_pos_zero", 32'(d1[9:0]), 32'd0);
      chk("t6_speed_nz", 32'(d1[22:19] != 4'd0), 32'd1);
      chk("t6_top_bit", 32'(d1[23]), 32'd1);
      @(posedge clk);
      #1;
      chk("t6_count", 32'(c1), 32'((i + 1) % 16));
    end
    chk("t6_count_wrapped", 32'(c1), 32'd1);
    @(negedge clk);
    en1 = 1'b0;
    rdy1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
